// File: rtl/obi_data_initiator.sv
// obi_data_initiator
// Scripted OBI data-port master: takes load/store commands on a valid/ready
// interface, issues them as OBI address phases, tracks granted transactions
// and returns their responses in order through a response FIFO. Issue is
// credit-limited against free FIFO space, so rvalid never needs backpressure.
module obi_data_initiator #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RSP_FIFO_DEPTH  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic                    cmd_we_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    output logic [ADDR_WIDTH-1:0]   data_addr_o,
    output logic                    data_we_o,
    output logic [DATA_WIDTH/8-1:0] data_be_o,
    output logic [DATA_WIDTH-1:0]   data_wdata_o,
    input  logic                    data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   data_rdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_we_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [3:0]              outstanding_o,
    output logic                    idle_o,
    output logic                    err_o
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int WE_PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int RSP_PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int RSP_CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

    localparam logic [WE_PTR_W-1:0]  WE_PTR_LAST  = WE_PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [RSP_PTR_W-1:0] RSP_PTR_LAST = RSP_PTR_W'(RSP_FIFO_DEPTH - 1);

    // Reject parameter sets whose credit scheme could overflow the FIFOs
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8 ||
        RSP_FIFO_DEPTH < MAX_OUTSTANDING || (DATA_WIDTH % 8) != 0) begin : g_param_check
        $error("obi_data_initiator: illegal MAX_OUTSTANDING/RSP_FIFO_DEPTH/DATA_WIDTH");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } req_state_e;

    req_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [BE_WIDTH-1:0]     be_q, be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              outstanding_q, outstanding_d;
    logic                    err_q, err_d;

    logic                    we_trk_q [MAX_OUTSTANDING];
    logic                    we_trk_d [MAX_OUTSTANDING];
    logic [WE_PTR_W-1:0]     we_wptr_q, we_wptr_d;
    logic [WE_PTR_W-1:0]     we_rptr_q, we_rptr_d;

    logic                    rsp_we_q [RSP_FIFO_DEPTH];
    logic                    rsp_we_d [RSP_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   rsp_data_q [RSP_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   rsp_data_d [RSP_FIFO_DEPTH];
    logic [RSP_PTR_W-1:0]    rsp_wptr_q, rsp_wptr_d;
    logic [RSP_PTR_W-1:0]    rsp_rptr_q, rsp_rptr_d;
    logic [RSP_CNT_W-1:0]    rsp_cnt_q, rsp_cnt_d;

    logic                    req_active;
    logic [3:0]              pending;
    logic [31:0]             credit_sum;
    logic                    cmd_accept;
    logic                    grant_fire;
    logic                    rvalid_err;
    logic                    rvalid_ok;
    logic                    track_push;
    logic                    rsp_push;
    logic                    rsp_pop;

    // Credit check and handshake qualifiers, built from registered counts only
    always_comb begin
        req_active  = (state_q == ST_REQ);
        pending     = outstanding_q + {3'b000, req_active};
        credit_sum  = 32'(pending) + 32'(rsp_cnt_q);
        cmd_ready_o = (!req_active || data_gnt_i)
                      && (32'(pending) < 32'(MAX_OUTSTANDING))
                      && (credit_sum < 32'(RSP_FIFO_DEPTH));
        cmd_accept  = cmd_valid_i && cmd_ready_o;
        grant_fire  = req_active && data_gnt_i;
        // An rvalid with nothing outstanding is a protocol violation, even if
        // the only transaction is being granted in the same cycle.
        rvalid_err  = data_rvalid_i && (outstanding_q == 4'd0);
        rvalid_ok   = data_rvalid_i && (outstanding_q != 4'd0);
        track_push  = grant_fire && !rvalid_err;
        rsp_push    = rvalid_ok;
        rsp_pop     = (rsp_cnt_q != '0) && rsp_ready_i;
    end

    // Address-phase request register: load on accept, release on grant
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (data_gnt_i && !cmd_accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (cmd_accept) begin
            addr_d  = cmd_addr_i;
            we_d    = cmd_we_i;
            be_d    = cmd_be_i;
            wdata_d = cmd_wdata_i;
        end
    end

    // Outstanding counter, in-order we tracking FIFO and sticky error flag
    always_comb begin
        outstanding_d = outstanding_q;
        we_trk_d      = we_trk_q;
        we_wptr_d     = we_wptr_q;
        we_rptr_d     = we_rptr_q;
        err_d         = err_q || rvalid_err;
        case ({track_push, rvalid_ok})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase
        if (track_push) begin
            we_trk_d[we_wptr_q] = we_q;
            we_wptr_d = (we_wptr_q == WE_PTR_LAST) ? '0 : we_wptr_q + WE_PTR_W'(1);
        end
        if (rvalid_ok) begin
            we_rptr_d = (we_rptr_q == WE_PTR_LAST) ? '0 : we_rptr_q + WE_PTR_W'(1);
        end
    end

    // Response FIFO: push on legal rvalid, pop on consumer handshake
    always_comb begin
        rsp_we_d   = rsp_we_q;
        rsp_data_d = rsp_data_q;
        rsp_wptr_d = rsp_wptr_q;
        rsp_rptr_d = rsp_rptr_q;
        rsp_cnt_d  = rsp_cnt_q;
        if (rsp_push) begin
            rsp_we_d[rsp_wptr_q]   = we_trk_q[we_rptr_q];
            rsp_data_d[rsp_wptr_q] = we_trk_q[we_rptr_q] ? '0 : data_rdata_i;
            rsp_wptr_d = (rsp_wptr_q == RSP_PTR_LAST) ? '0 : rsp_wptr_q + RSP_PTR_W'(1);
        end
        if (rsp_pop) begin
            rsp_rptr_d = (rsp_rptr_q == RSP_PTR_LAST) ? '0 : rsp_rptr_q + RSP_PTR_W'(1);
        end
        case ({rsp_push, rsp_pop})
            2'b10:   rsp_cnt_d = rsp_cnt_q + RSP_CNT_W'(1);
            2'b01:   rsp_cnt_d = rsp_cnt_q - RSP_CNT_W'(1);
            default: rsp_cnt_d = rsp_cnt_q;
        endcase
    end

    // Control state with synchronous reset; reset drops all in-flight work
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            we_q          <= 1'b0;
            be_q          <= '0;
            wdata_q       <= '0;
            outstanding_q <= 4'd0;
            err_q         <= 1'b0;
            we_wptr_q     <= '0;
            we_rptr_q     <= '0;
            rsp_wptr_q    <= '0;
            rsp_rptr_q    <= '0;
            rsp_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            we_wptr_q     <= we_wptr_d;
            we_rptr_q     <= we_rptr_d;
            rsp_wptr_q    <= rsp_wptr_d;
            rsp_rptr_q    <= rsp_rptr_d;
            rsp_cnt_q     <= rsp_cnt_d;
        end
    end

    // FIFO storage needs no reset: pointers and count define what is valid
    always_ff @(posedge clk_i) begin
        we_trk_q   <= we_trk_d;
        rsp_we_q   <= rsp_we_d;
        rsp_data_q <= rsp_data_d;
    end

    // Outputs; head fields are forced to zero while the FIFO is empty
    always_comb begin
        data_req_o    = req_active;
        data_addr_o   = addr_q;
        data_we_o     = we_q;
        data_be_o     = be_q;
        data_wdata_o  = wdata_q;
        rsp_valid_o   = (rsp_cnt_q != '0);
        rsp_we_o      = rsp_valid_o ? rsp_we_q[rsp_rptr_q] : 1'b0;
        rsp_rdata_o   = rsp_valid_o ? rsp_data_q[rsp_rptr_q] : '0;
        outstanding_o = outstanding_q;
        idle_o        = !req_active && (outstanding_q == 4'd0) && (rsp_cnt_q == '0);
        err_o         = err_q;
    end

endmodule
